dlsc_pcie_s6_outbound_read_mux: RTL and testbench



---
 rtl/dlsc_pcie_s6_outbound_read_mux.sv | 198 +++++++++++++++++++
 tb/tb_dlsc_pcie_s6_outbound_read_mux.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlsc_pcie_s6_outbound_read_mux.sv
// Multi-channel outbound read requester: arbitrates AXI AR ports and splits each command into PCIe MRd headers.
// Define DLSC_PCIE_S6_OUTBOUND_READ_RR_EN for round-robin arbitration; otherwise fixed priority (channel 0 highest).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for an AR; the accepted command's first header loads directly
// SPLIT   | issuing the remaining headers; leaves when the last header is taken
module dlsc_pcie_s6_outbound_read_mux #(
    parameter int ADDR     = 32,
    parameter int LEN      = 4,
    parameter int CHANNELS = 2,
    parameter int CHB      = 1,
    parameter int MAX_SIZE = 128,
    parameter int TAGS     = 8,
    parameter int TAGB     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [CHANNELS-1:0]      axi_ar_ready,
    input  logic [CHANNELS-1:0]      axi_ar_valid,
    input  logic [CHANNELS*ADDR-1:0] axi_ar_addr,
    input  logic [CHANNELS*LEN-1:0]  axi_ar_len,
    input  logic [2:0]               max_read_request,
    input  logic                     tlp_h_ready,
    output logic                     tlp_h_valid,
    output logic [ADDR-3:0]          tlp_h_addr,
    output logic [9:0]               tlp_h_len,
    output logic [TAGB-1:0]          tlp_h_tag,
    output logic [CHB-1:0]           tlp_h_chan,
    output logic                     tlp_h_last,
    input  logic                     cpl_valid,
    input  logic [TAGB-1:0]          cpl_tag
);

    localparam int MAX_DW = (MAX_SIZE / 4 > 1024) ? 1024 : MAX_SIZE / 4;

    typedef enum logic [0:0] {ST_IDLE, ST_SPLIT} state_t;

    state_t          state, state_next;
    logic [CHB-1:0]  grant;
    logic            grant_found;
    logic            ar_hs;
    logic            load;
    logic            hdr_done;
    logic            tag_free;
    logic [TAGB-1:0] alloc_tag;
    logic [TAGS-1:0] busy, busy_next;
    logic [ADDR-3:0] cur_addr;
    logic [10:0]     remaining;
    logic [CHB-1:0]  cur_chan;
    logic [ADDR-1:0] sel_addr;
    logic [LEN-1:0]  sel_len;
    logic [ADDR-3:0] src_addr;
    logic [10:0]     src_rem;
    logic [CHB-1:0]  src_chan;
    logic [2:0]      mrr_sel;
    logic [10:0]     mrr_dw;
    logic [10:0]     dw_to_4k;
    logic [10:0]     tlp_len;
    logic            addr_lsb_unused;
`ifdef DLSC_PCIE_S6_OUTBOUND_READ_RR_EN
    logic [CHB-1:0]  rr_ptr;
`endif

    // Arbiter: rr_ptr holds the first channel to search (one past the last grant).
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
`ifdef DLSC_PCIE_S6_OUTBOUND_READ_RR_EN
            if (!grant_found && axi_ar_valid[(int'(rr_ptr) + k) % CHANNELS]) begin
                grant       = CHB'((int'(rr_ptr) + k) % CHANNELS);
                grant_found = 1'b1;
            end
`else
            if (!grant_found && axi_ar_valid[k]) begin
                grant       = CHB'(k);
                grant_found = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        tag_free  = 1'b0;
        alloc_tag = '0;
        for (int i = TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                tag_free  = 1'b1;
                alloc_tag = TAGB'(i);
            end
        end
    end

    assign sel_addr        = axi_ar_addr[grant*ADDR +: ADDR];
    assign sel_len         = axi_ar_len[grant*LEN +: LEN];
    assign addr_lsb_unused = ^sel_addr[1:0];

    assign ar_hs    = (state == ST_IDLE) && !rst && grant_found && tag_free;
    assign hdr_done = tlp_h_valid && tlp_h_ready && tlp_h_last;

    // In IDLE the first header is built straight from the AR so it appears one cycle after the handshake.
    assign src_addr = (state == ST_IDLE) ? sel_addr[ADDR-1:2] : cur_addr;
    assign src_rem  = (state == ST_IDLE) ? (11'(sel_len) + 11'd1) : remaining;
    assign src_chan = (state == ST_IDLE) ? grant : cur_chan;

    always_comb begin
        mrr_sel  = (max_read_request > 3'd5) ? 3'd5 : max_read_request;
        mrr_dw   = 11'd32 << mrr_sel;
        if (mrr_dw > 11'(MAX_DW))
            mrr_dw = 11'(MAX_DW);
        dw_to_4k = 11'd1024 - {1'b0, src_addr[9:0]};
        tlp_len  = src_rem;
        if (mrr_dw < tlp_len)
            tlp_len = mrr_dw;
        if (dw_to_4k < tlp_len)
            tlp_len = dw_to_4k;
    end

    always_comb begin
        if (state == ST_IDLE)
            load = ar_hs;
        else
            load = (remaining != 11'd0) && (!tlp_h_valid || tlp_h_ready) && tag_free;
    end

    always_comb begin
        busy_next = busy;
        for (int i = 0; i < TAGS; i++) begin
            if (cpl_valid && (cpl_tag == TAGB'(i)))
                busy_next[i] = 1'b0;
            if (load && (alloc_tag == TAGB'(i)))
                busy_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (ar_hs)    state_next = ST_SPLIT;
            ST_SPLIT: if (hdr_done) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        axi_ar_ready = '0;
        if (ar_hs)
            axi_ar_ready = CHANNELS'(1) << grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr    <= '0;
            remaining   <= '0;
            cur_chan    <= '0;
            busy        <= '0;
            tlp_h_valid <= 1'b0;
            tlp_h_addr  <= '0;
            tlp_h_len   <= '0;
            tlp_h_tag   <= '0;
            tlp_h_chan  <= '0;
            tlp_h_last  <= 1'b0;
        end else begin
            busy <= busy_next;
            if (load) begin
                cur_addr    <= src_addr + (ADDR-2)'(tlp_len);
                remaining   <= src_rem - tlp_len;
                cur_chan    <= src_chan;
                tlp_h_valid <= 1'b1;
                tlp_h_addr  <= src_addr;
                tlp_h_len   <= tlp_len[9:0];
                tlp_h_tag   <= alloc_tag;
                tlp_h_chan  <= src_chan;
                tlp_h_last  <= (src_rem == tlp_len);
            end else if (tlp_h_ready) begin
                tlp_h_valid <= 1'b0;
            end
        end
    end

`ifdef DLSC_PCIE_S6_OUTBOUND_READ_RR_EN
    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (ar_hs)
            rr_ptr <= (grant == CHB'(CHANNELS - 1)) ? '0 : grant + CHB'(1);
    end
`endif

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_read_mux.sv
// Scoreboard bench for dlsc_pcie_s6_outbound_read_mux: directed commands push expected headers, a monitor checks them.
module tb_dlsc_pcie_s6_outbound_read_mux;

    localparam int ADDR = 32, LEN = 10, CHANNELS = 2, CHB = 1, MAX_SIZE = 4096, TAGS = 4, TAGB = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [CHANNELS-1:0]      axi_ar_ready;
    logic [CHANNELS-1:0]      axi_ar_valid;
    logic [CHANNELS*ADDR-1:0] axi_ar_addr;
    logic [CHANNELS*LEN-1:0]  axi_ar_len;
    logic [2:0]               max_read_request;
    logic                     tlp_h_ready;
    logic                     tlp_h_valid;
    logic [ADDR-3:0]          tlp_h_addr;
    logic [9:0]               tlp_h_len;
    logic [TAGB-1:0]          tlp_h_tag;
    logic [CHB-1:0]           tlp_h_chan;
    logic                     tlp_h_last;
    logic                     cpl_valid;
    logic [TAGB-1:0]          cpl_tag;

    typedef struct {
        logic [ADDR-3:0] addr;
        logic [9:0]      len;
        logic [TAGB-1:0] tag;
        logic [CHB-1:0]  chan;
        logic            last;
    } hdr_t;

    hdr_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dlsc_pcie_s6_outbound_read_mux #(
        .ADDR(ADDR), .LEN(LEN), .CHANNELS(CHANNELS), .CHB(CHB),
        .MAX_SIZE(MAX_SIZE), .TAGS(TAGS), .TAGB(TAGB)
    ) dut (
        .clk(clk), .rst(rst),
        .axi_ar_ready(axi_ar_ready), .axi_ar_valid(axi_ar_valid),
        .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
        .max_read_request(max_read_request),
        .tlp_h_ready(tlp_h_ready), .tlp_h_valid(tlp_h_valid),
        .tlp_h_addr(tlp_h_addr), .tlp_h_len(tlp_h_len), .tlp_h_tag(tlp_h_tag),
        .tlp_h_chan(tlp_h_chan), .tlp_h_last(tlp_h_last),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push(input logic [ADDR-3:0] a, input logic [9:0] l, input logic [TAGB-1:0] t,
                        input logic [CHB-1:0] c, input logic last);
        hdr_t h;
        h.addr = a; h.len = l; h.tag = t; h.chan = c; h.last = last;
        exp_q.push_back(h);
    endtask

    // Monitor: every accepted header must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && tlp_h_valid && tlp_h_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL hdr_unexpected got addr=%h len=%0d tag=%0d chan=%0d last=%0d",
                         tlp_h_addr, tlp_h_len, tlp_h_tag, tlp_h_chan, tlp_h_last);
            end else begin
                hdr_t e;
                e = exp_q.pop_front();
                if (tlp_h_addr !== e.addr || tlp_h_len !== e.len || tlp_h_tag !== e.tag ||
                    tlp_h_chan !== e.chan || tlp_h_last !== e.last) begin
                    failures++;
                    $display("FAIL hdr got addr=%h len=%0d tag=%0d chan=%0d last=%0d exp addr=%h len=%0d tag=%0d chan=%0d last=%0d",
                             tlp_h_addr, tlp_h_len, tlp_h_tag, tlp_h_chan, tlp_h_last,
                             e.addr, e.len, e.tag, e.chan, e.last);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that completes the handshake.
    task automatic issue(input int ch, input logic [ADDR-1:0] a, input logic [LEN-1:0] l);
        bit done = 0;
        axi_ar_addr[ch*ADDR +: ADDR] = a;
        axi_ar_len[ch*LEN +: LEN]    = l;
        axi_ar_valid[ch]             = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (axi_ar_ready[ch]) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        axi_ar_valid[ch] = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL ar_timeout ch=%0d got=no_handshake exp=handshake", ch);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_tag(input logic [TAGB-1:0] t);
        cpl_valid = 1'b1;
        cpl_tag   = t;
        @(posedge clk);
        #1;
        cpl_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !tlp_h_valid)
                done = 1;
        end
        check("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CHANNELS-1:0] r;
        int cnt0, cnt1, grants;

        rst = 1'b1; axi_ar_valid = '1; axi_ar_addr = '0; axi_ar_len = '0;
        max_read_request = 3'd0; tlp_h_ready = 1'b1; cpl_valid = 1'b0; cpl_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(tlp_h_valid), 0);
        check("rst_addr", 32'(tlp_h_addr), 0);
        check("rst_len", 32'(tlp_h_len), 0);
        check("rst_tag", 32'(tlp_h_tag), 0);
        check("rst_chan", 32'(tlp_h_chan), 0);
        check("rst_last", 32'(tlp_h_last), 0);
        check("rst_ar_ready", 32'(axi_ar_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0; axi_ar_valid = '0;
        @(posedge clk);
        #1;

        // Single 16-DW read, header one cycle after the AR handshake.
        max_read_request = 3'd0;
        push(30'h400, 10'd16, 2'd0, 1'b0, 1'b1);
        issue(0, 32'h0000_1000, 10'd15);
        @(negedge clk);
        check("latency_valid", 32'(tlp_h_valid), 1);
        @(posedge clk);
        #1;
        drain();
        release_tag(2'd0);

        // 1024 DW from byte 0xFC0: 16 DW up to the 4 KB line, then 1008 DW; mrr 7 acts as 4096 B.
        max_read_request = 3'd7;
        push(30'h3F0, 10'd16, 2'd0, 1'b0, 1'b0);
        push(30'h400, 10'd1008, 2'd1, 1'b0, 1'b1);
        issue(0, 32'h0000_0FC0, 10'd1023);
        drain();
        release_tag(2'd0);
        release_tag(2'd1);

        // 512 B at 0x2000 with 128 B requests on channel 1; first header held for 5 cycles.
        max_read_request = 3'd0;
        tlp_h_ready = 1'b0;
        push(30'h800, 10'd32, 2'd0, 1'b1, 1'b0);
        push(30'h820, 10'd32, 2'd1, 1'b1, 1'b0);
        push(30'h840, 10'd32, 2'd2, 1'b1, 1'b0);
        push(30'h860, 10'd32, 2'd3, 1'b1, 1'b1);
        issue(1, 32'h0000_2000, 10'd127);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_hdr", {tlp_h_valid, tlp_h_addr[20:0], tlp_h_len},
                  {1'b1, 21'h800, 10'd32});
        end
        @(posedge clk);
        #1;
        tlp_h_ready = 1'b1;
        drain();
        for (int t = 0; t < 4; t++) release_tag(TAGB'(t));

        // Exhaust all four tags, then a fifth command stalls until tag 2 comes back.
        for (int k = 0; k < 4; k++) begin
            push(30'h1000 + 30'(k * 32), 10'd32, TAGB'(k), 1'b0, 1'b1);
            issue(0, 32'h0000_4000 + 32'(k * 128), 10'd31);
        end
        push(30'h1080, 10'd32, 2'd2, 1'b0, 1'b1);
        fork
            issue(0, 32'h0000_4200, 10'd31);
        join_none
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("stall_valid", 32'(tlp_h_valid), 0);
        check("stall_ar_ready", 32'(axi_ar_ready), 0);
        @(posedge clk);
        #1;
        cpl_valid = 1'b1; cpl_tag = 2'd2;
        @(posedge clk);
        #1;
        cpl_valid = 1'b0;
        @(negedge clk);
        check("release_no_bypass", 32'(tlp_h_valid), 0);
        @(negedge clk);
        check("release_plus2", {tlp_h_valid, 6'(tlp_h_tag)}, {1'b1, 6'd2});
        @(posedge clk);
        #1;
        drain();
        for (int t = 0; t < 4; t++) release_tag(TAGB'(t));

        // Reset while the second of four split headers is pending.
        push(30'h800, 10'd32, 2'd0, 1'b0, 1'b0);
        push(30'h820, 10'd32, 2'd1, 1'b0, 1'b0);
        push(30'h840, 10'd32, 2'd2, 1'b0, 1'b0);
        push(30'h860, 10'd32, 2'd3, 1'b0, 1'b1);
        issue(0, 32'h0000_2000, 10'd127);
        @(posedge clk);
        #1;
        tlp_h_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        tlp_h_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(tlp_h_valid), 0);
        @(posedge clk);
        #1;
        push(30'h1C00, 10'd1, 2'd0, 1'b1, 1'b1);
        issue(1, 32'h0000_7000, 10'd0);
        drain();
        release_tag(2'd0);

        // Both channels requesting continuously, single-DW commands.
`ifdef DLSC_PCIE_S6_OUTBOUND_READ_RR_EN
        push(30'h1400, 10'd1, 2'd0, 1'b0, 1'b1);
        push(30'h1800, 10'd1, 2'd1, 1'b1, 1'b1);
        push(30'h1401, 10'd1, 2'd2, 1'b0, 1'b1);
        push(30'h1801, 10'd1, 2'd3, 1'b1, 1'b1);
`else
        push(30'h1400, 10'd1, 2'd0, 1'b0, 1'b1);
        push(30'h1401, 10'd1, 2'd1, 1'b0, 1'b1);
        push(30'h1402, 10'd1, 2'd2, 1'b0, 1'b1);
        push(30'h1403, 10'd1, 2'd3, 1'b0, 1'b1);
`endif
        cnt0 = 0; cnt1 = 0; grants = 0;
        axi_ar_addr = {32'h0000_6000, 32'h0000_5000};
        axi_ar_len  = '0;
        axi_ar_valid = 2'b11;
        for (int c = 0; c < 100 && grants < 4; c++) begin
            @(negedge clk);
            r = axi_ar_ready;
            @(posedge clk);
            #1;
            if (r[0]) begin cnt0++; grants++; axi_ar_addr[31:0]  = 32'h0000_5000 + 32'(cnt0 * 4); end
            if (r[1]) begin cnt1++; grants++; axi_ar_addr[63:32] = 32'h0000_6000 + 32'(cnt1 * 4); end
        end
        axi_ar_valid = '0;
        check("arb_grants", grants, 4);
        drain();
        for (int t = 0; t < 4; t++) release_tag(TAGB'(t));

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
